// File: rtl/spi_bridge_pkg.sv
// Shared constants for the SPI-to-register-bus bridge: one-hot state
// encoding, default error data and timeout limits.
package spi_bridge_pkg;

    localparam logic [3:0] ST_IDLE_OH    = 4'b0001;
    localparam logic [3:0] ST_RD_REQ_OH  = 4'b0010;
    localparam logic [3:0] ST_WR_WAIT_OH = 4'b0100;
    localparam logic [3:0] ST_WR_REQ_OH  = 4'b1000;

    localparam int S_IDLE_B    = 0;
    localparam int S_RD_REQ_B  = 1;
    localparam int S_WR_WAIT_B = 2;
    localparam int S_WR_REQ_B  = 3;

    typedef enum logic [3:0] {
        S_IDLE    = ST_IDLE_OH,
        S_RD_REQ  = ST_RD_REQ_OH,
        S_WR_WAIT = ST_WR_WAIT_OH,
        S_WR_REQ  = ST_WR_REQ_OH
    } state_e;

    localparam logic [31:0] DEF_ERR_DATA       = 32'hDEAD_BEEF;
    localparam int          DEF_TIMEOUT_CYCLES = 64;
    localparam int          TIMEOUT_MAX        = 255;
    localparam int          TIMER_W            = 8;

    // Keep the programmed limit inside the counter's legal 1..255 range.
    function automatic logic [TIMER_W-1:0] timer_limit(input int cycles);
        if (cycles > TIMEOUT_MAX) begin
            return TIMER_W'(TIMEOUT_MAX);
        end
        if (cycles < 1) begin
            return TIMER_W'(1);
        end
        return TIMER_W'(cycles);
    endfunction

endpackage

// File: rtl/spi_bridge_if.sv
// Internal register bus bundle between the bridge and the register block.
// master: BusReq/BusWr/BusAddr/BusWData out, BusAck/BusRData in.
interface spi_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) ();

    logic                  BusReq;
    logic                  BusWr;
    logic [ADDR_WIDTH-1:0] BusAddr;
    logic [DATA_WIDTH-1:0] BusWData;
    logic                  BusAck;
    logic [DATA_WIDTH-1:0] BusRData;

    modport master (
        output BusReq,
        output BusWr,
        output BusAddr,
        output BusWData,
        input  BusAck,
        input  BusRData
    );

    modport slave (
        input  BusReq,
        input  BusWr,
        input  BusAddr,
        input  BusWData,
        output BusAck,
        output BusRData
    );

endinterface

// File: rtl/spi_bridge_timer.sv
// Bus request watchdog: counts request cycles and pulses expire on the
// cycle whose closing edge brings the count up to limit.
// Ports: clk, rst_n, clear, enable, limit[7:0] in; expire out.
module spi_bridge_timer
    import spi_bridge_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [TIMER_W-1:0] limit,
    output logic               expire
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;
    logic [TIMER_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + TIMER_W'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_inc;
        end
    end

    // Look one count ahead so expiry lands on the edge that completes
    // the limit-th request cycle.
    assign expire = enable & ~clear & (cnt_inc == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// Turns decoded SPI slave transactions into single-beat register bus
// requests and returns read data to the slave's TX path.
// Ports: Clk, aRst_n; SPI side RWType/RXAddr*/RXData*/TXData*;
// register bus via spi_bridge_if.master; Timeout and Overrun pulses.
// Build option: SPI_BRIDGE_TIMEOUT_EN compiles in the request timeout.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DEF_ERR_DATA
) (
    input  logic                  Clk,
    input  logic                  aRst_n,
    input  logic                  RWType,
    input  logic [ADDR_WIDTH-1:0] RXAddr,
    input  logic                  RXAddrValid,
    input  logic [DATA_WIDTH-1:0] RXData,
    input  logic                  RXDataValid,
    output logic [DATA_WIDTH-1:0] TXData,
    output logic                  TXDataValid,
    output logic                  Timeout,
    output logic                  Overrun,
    spi_bridge_if.master          bus
);

    state_e                state_q;
    state_e                state_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q;
    logic [ADDR_WIDTH-1:0] bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q;
    logic [DATA_WIDTH-1:0] bus_wdata_d;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic [DATA_WIDTH-1:0] tx_data_d;
    logic                  tx_valid_q;
    logic                  tx_valid_d;
    logic                  timeout_q;
    logic                  timeout_d;
    logic                  overrun_q;
    logic                  overrun_d;
    logic                  bus_req;
    logic                  expire;

    assign bus_req = state_q[S_RD_REQ_B] | state_q[S_WR_REQ_B];

`ifdef SPI_BRIDGE_TIMEOUT_EN
    // Counter sits at zero whenever no request is outstanding, so it is
    // freshly cleared on every entry into a request state.
    spi_bridge_timer u_timer (
        .clk    (Clk),
        .rst_n  (aRst_n),
        .clear  (~bus_req),
        .enable (bus_req),
        .limit  (timer_limit(TIMEOUT_CYCLES)),
        .expire (expire)
    );
    assign Timeout = timeout_q;
`else
    logic unused_cfg;
    assign expire     = 1'b0;
    assign Timeout    = 1'b0;
    assign unused_cfg = ^{timeout_q, TIMER_W'(TIMEOUT_CYCLES)};
`endif

    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = 1'b0;
        timeout_d   = 1'b0;
        overrun_d   = 1'b0;
        unique case (1'b1)
            // A fresh address in WR_WAIT means the frame was aborted;
            // it re-decodes as from IDLE and beats same-cycle data.
            state_q[S_IDLE_B], state_q[S_WR_WAIT_B]: begin
                if (RXAddrValid) begin
                    bus_addr_d = RXAddr;
                    state_d    = RWType ? S_WR_WAIT : S_RD_REQ;
                end else if (state_q[S_WR_WAIT_B] && RXDataValid) begin
                    bus_wdata_d = RXData;
                    state_d     = S_WR_REQ;
                end
            end
            state_q[S_RD_REQ_B]: begin
                overrun_d = RXAddrValid;
                if (bus.BusAck) begin
                    tx_data_d  = bus.BusRData;
                    tx_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (expire) begin
                    tx_data_d  = ERR_DATA;
                    tx_valid_d = 1'b1;
                    timeout_d  = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            state_q[S_WR_REQ_B]: begin
                overrun_d = RXAddrValid;
                if (bus.BusAck) begin
                    state_d = S_IDLE;
                end else if (expire) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge aRst_n) begin
        if (!aRst_n) begin
            state_q     <= S_IDLE;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.BusReq   = bus_req;
    assign bus.BusWr    = state_q[S_WR_REQ_B];
    assign bus.BusAddr  = bus_addr_q;
    assign bus.BusWData = bus_wdata_q;
    assign TXData       = tx_data_q;
    assign TXDataValid  = tx_valid_q;
    assign Overrun      = overrun_q;

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Converts decoded SPI slave transactions into single-beat requests on the chip's internal register bus. It sits directly downstream of the SPI slave. It consumes that block's `RWType`, `RXAddr`/`RXAddrValid` and `RXData`/`RXDataValid` outputs. For reads, it returns register data through `TXData`/`TXDataValid` in time for the slave's TX phase.

## Interface
- `DATA_WIDTH`, 32: register/SPI data width.
- `ADDR_WIDTH`, 16: register address width.
- `TIMEOUT_CYCLES`, 64: maximum `Clk` cycles `BusReq` waits for `BusAck`. Legal range is 1..255.
- `ERR_DATA`, 32'hDEAD_BEEF: value returned on `TXData` when a read times out.

Ports:
- `Clk`  in  1  system clock; single clock domain.
- `aRst_n`  in  1  asynchronous, active-low reset.
- `RWType`  in  1  transaction type from the SPI slave: 1 = write, 0 = read. Valid when `RXAddrValid` is high.
- `RXAddr`  in  ADDR_WIDTH  address from the SPI slave.
- `RXAddrValid`  in  1  one-cycle pulse; address and `RWType` are valid.
- `RXData`  in  DATA_WIDTH  write data from the SPI slave.
- `RXDataValid`  in  1  one-cycle pulse; write data is valid.
- `TXData`  out  DATA_WIDTH  read data to the SPI slave.
- `TXDataValid`  out  1  one-cycle pulse; `TXData` is valid.
- `BusReq`  out  1  bus request; held high until acknowledged.
- `BusWr`  out  1  1 = write, 0 = read. Valid while `BusReq` is high.
- `BusAddr`  out  ADDR_WIDTH  bus address.
- `BusWData`  out  DATA_WIDTH  bus write data.
- `BusAck`  in  1  single-cycle acknowledge; `BusRData` is valid in the same cycle.
- `BusRData`  in  DATA_WIDTH  bus read data.
- `Timeout`  out  1  one-cycle pulse when a bus request is abandoned.
- `Overrun`  out  1  one-cycle pulse when an `RXAddrValid` arrives while a bus request is in flight.

## Operation
The state machine uses one-hot encoding with four states: IDLE, RD_REQ, WR_WAIT, WR_REQ.
- **IDLE**
  - On `RXAddrValid`, latch `RXAddr` into `BusAddr`.
  - If `RWType` = 0, go to RD_REQ. If `RWType` = 1, go to WR_WAIT.
- **RD_REQ**
  - `BusReq` = 1, `BusWr` = 0.
  - On `BusAck`: `TXData` <= `BusRData`, pulse `TXDataValid`, go to IDLE.
  - On timeout: `TXData` <= `ERR_DATA`, pulse `TXDataValid` and `Timeout`, go to IDLE.
- **WR_WAIT**
  - On `RXDataValid`: `BusWData` <= `RXData`, go to WR_REQ.
  - On a new `RXAddrValid` (the previous frame was aborted by CS rising): discard the pending write and re-decode exactly as in IDLE.
- **WR_REQ**
  - `BusReq` = 1, `BusWr` = 1.
  - On `BusAck` or timeout, go to IDLE. A timeout also pulses `Timeout`.
- **Request states in general**
  - `BusAddr`, `BusWr` and `BusWData` stay stable while `BusReq` is high.
  - An `RXAddrValid` arriving in RD_REQ or WR_REQ is dropped and pulses `Overrun`. The request in flight still completes.
  - `RXDataValid` outside WR_WAIT is ignored.
- **Simultaneous events**
  - `BusAck` in the same cycle as timeout expiry: the ack wins and real data is returned.
  - `RXAddrValid` and `RXDataValid` in the same cycle in WR_WAIT: the address wins and the data is discarded.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- `RXAddrValid` sampled high at edge n gives `BusReq` high after edge n.
- `BusAck` sampled high at edge m: after edge m, `BusReq` is low and `TXDataValid` is high for exactly one cycle. The block is back in IDLE and can accept `RXAddrValid` on the next edge.
- `RXDataValid` sampled at edge k (in WR_WAIT) gives `BusReq` high after edge k.
- Timeout counter:
  - Clears when a request state is entered and increments every cycle while `BusReq` is high.
  - Expires on the edge where the count equals `TIMEOUT_CYCLES` with `BusAck` low. With `TIMEOUT_CYCLES` = 4 and no ack, `BusReq` is high for 4 cycles.
- Integration constraint: `TIMEOUT_CYCLES` + 3 must be less than the `Clk` cycles in one SCK period. The slave's address-ack bit is then certain to cover the read turnaround.
- Reset mid-operation: asserting `aRst_n` low clears all outputs asynchronously, including a `BusReq` in flight. No pulse is emitted.

## Configuration
- `SPI_BRIDGE_TIMEOUT_EN` defined:
  - The timeout counter is compiled in and behaves as described above.
- Undefined:
  - There is no counter, and request states wait indefinitely for `BusAck`.
  - `Timeout` is tied to 0, `TIMEOUT_CYCLES` and `ERR_DATA` are unused, and `ERR_DATA` is never returned.

## Structure
- Package `spi_bridge_pkg` holds:
  - the one-hot state encoding localparams (4 bits);
  - the default `ERR_DATA`;
  - the `TIMEOUT_CYCLES` limit.
- One sub-module, `spi_bridge_timer`:
  - Inputs: clear, enable, limit. Output: expire pulse.
  - Instantiated only under `SPI_BRIDGE_TIMEOUT_EN`.

## Test plan
- **Read:** `RXAddrValid`, `RWType` = 0, `RXAddr` = 16'h0010; `BusAck` after 3 cycles with `BusRData` = 32'h1234_5678. Required: `BusAddr` = 0x0010, `BusWr` = 0, `TXData` = 32'h1234_5678, one-cycle `TXDataValid` one cycle after the ack.
- **Write:** address 16'h00A0 with `RWType` = 1, then `RXDataValid` with 32'hCAFE_F00D 40 cycles later. Required: `BusReq` rises one cycle after `RXDataValid`, `BusWr` = 1, `BusWData` = 32'hCAFE_F00D.
- **Timeout (macro on, `TIMEOUT_CYCLES` = 4):** read with no ack. Required: `BusReq` high for 4 cycles, `TXData` = 32'hDEAD_BEEF, `TXDataValid` and `Timeout` pulse together. With the macro off, `BusReq` stays high through 1000 cycles.
- **Aborted write:** write address 16'h0001, then a new `RXAddrValid` read of 16'h0002 before any `RXDataValid`. Required: no write request is issued, and a read of 0x0002 is issued.
- **Overrun:** `RXAddrValid` while in RD_REQ. Required: `Overrun` pulses, `BusAddr` is unchanged, and the original read completes.
- **Reset mid-request:** `aRst_n` low while `BusReq` = 1. Required: `BusReq` and all other outputs go to 0 immediately; after release, the next `RXAddrValid` is handled normally.
